// File: rtl/mem_access_stage_pkg.sv
// Shared MEM-stage types: FSM state encoding, default widths and the MEM/WB register bundle.
package mem_access_stage_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic                  valid;
        logic                  rf_we;
        logic [MEM_DATA_W-1:0] data;
        logic                  next_pc;
        logic                  rf_d_sel;
        logic                  err;
    } mem_wb_t;

    // An instruction needs the data memory when it is a real load or store.
    function automatic logic is_access(input logic valid, input logic we, input logic rd_sel);
        return valid & (we | rd_sel);
    endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Cycle counter for an outstanding memory request; expired marks the last allowed REQ cycle.
module mem_timeout_cnt #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_r;

    // Counter register: clear has priority over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: req/ack data-memory access with upstream stall and MEM/WB output register.
// The MEM/WB bundle width comes from the package, so DATA_W must stay equal to MEM_DATA_W.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_dm_we,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [ADDR_W-1:0] in_dm_addr,
    input  logic              in_next_pc,
    input  logic              in_rf_d_sel,
    output logic              stall,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_ack,
    output logic              wb_valid,
    output logic              wb_rf_we,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_next_pc,
    output logic              wb_rf_d_sel,
    output logic              wb_err
);

    mem_state_t state_r;
    mem_state_t state_nxt_s;
    mem_wb_t    wb_r;
    mem_wb_t    wb_nxt_s;
    logic       is_acc_s;
    logic       cnt_clr_s;
    logic       cnt_en_s;
    logic       expired_s;

    assign is_acc_s = is_access(in_valid, in_dm_we, in_rf_d_sel);

    mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clr_s),
        .enable  (cnt_en_s),
        .expired (expired_s)
    );

    // State and MEM/WB register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            wb_r    <= '0;
        end else begin
            state_r <= state_nxt_s;
            wb_r    <= wb_nxt_s;
        end
    end

    // Next state, stall, counter control and next MEM/WB contents.
    always_comb begin
        state_nxt_s       = state_r;
        stall             = 1'b0;
        cnt_clr_s         = 1'b1;
        cnt_en_s          = 1'b0;
        wb_nxt_s          = wb_r;
        wb_nxt_s.valid    = 1'b0;
        case (state_r)
            IDLE: begin
                if (is_acc_s) begin
                    stall       = 1'b1;
                    state_nxt_s = REQ;
                end else if (in_valid) begin
                    wb_nxt_s = '{valid: 1'b1, rf_we: 1'b1, data: in_alu_res,
                                 next_pc: in_next_pc, rf_d_sel: in_rf_d_sel, err: 1'b0};
                end else begin
                    wb_nxt_s.valid = 1'b0;
                end
            end
            REQ: begin
                cnt_clr_s = 1'b0;
                // Ack beats a coincident timeout.
                if (dm_ack) begin
                    state_nxt_s = IDLE;
                    cnt_clr_s   = 1'b1;
                    wb_nxt_s    = '{valid: 1'b1, rf_we: ~in_dm_we,
                                    data: in_rf_d_sel ? dm_rdata : in_alu_res,
                                    next_pc: in_next_pc, rf_d_sel: in_rf_d_sel, err: 1'b0};
                end else if (expired_s) begin
                    state_nxt_s = IDLE;
                    cnt_clr_s   = 1'b1;
                    wb_nxt_s    = '{valid: 1'b1, rf_we: 1'b0, data: {DATA_W{1'b0}},
                                    next_pc: in_next_pc, rf_d_sel: in_rf_d_sel, err: 1'b1};
                end else begin
                    stall    = 1'b1;
                    cnt_en_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign dm_req      = (state_r == REQ);
    assign dm_we       = dm_req & in_dm_we;
    assign dm_addr     = dm_req ? in_dm_addr : {ADDR_W{1'b0}};
    assign dm_wdata    = dm_req ? in_store_data : {DATA_W{1'b0}};

    assign wb_valid    = wb_r.valid;
    assign wb_rf_we    = wb_r.rf_we;
    assign wb_data     = wb_r.data;
    assign wb_next_pc  = wb_r.next_pc;
    assign wb_rf_d_sel = wb_r.rf_d_sel;
    assign wb_err      = wb_r.err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus a randomized instruction stream.
module tb_mem_access_stage;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 15;
    localparam int NEVER = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_dm_we, in_next_pc, in_rf_d_sel;
    logic [DW-1:0] in_alu_res, in_store_data, dm_rdata;
    logic [AW-1:0] in_dm_addr;
    logic          dm_ack;
    logic          stall, dm_req, dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, wb_data;
    logic          wb_valid, wb_rf_we, wb_next_pc, wb_rf_d_sel, wb_err;

    int total = 0;
    int bad   = 0;

    // Reference state: what the MEM/WB register should hold.
    logic [DW-1:0] m_data;
    logic          m_rf_we, m_err, m_np, m_rs;

    // Observations from the last drive_instr call.
    int            o_stall, o_req, o_bus_bad;
    logic          o_wb;

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_dm_we(in_dm_we),
        .in_alu_res(in_alu_res), .in_store_data(in_store_data), .in_dm_addr(in_dm_addr),
        .in_next_pc(in_next_pc), .in_rf_d_sel(in_rf_d_sel), .stall(stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .wb_valid(wb_valid), .wb_rf_we(wb_rf_we),
        .wb_data(wb_data), .wb_next_pc(wb_next_pc), .wb_rf_d_sel(wb_rf_d_sel), .wb_err(wb_err)
    );

    // Abstract model: an instruction either passes, completes with memory after dly
    // unacked REQ cycles, or times out after TO REQ cycles.
    task automatic model_step(input logic v, input logic we, input logic rs, input logic np,
                              input logic [DW-1:0] alu, input logic [DW-1:0] rd, input int dly,
                              output logic e_wb, output int e_stall, output int e_req);
        e_wb = v; e_stall = 0; e_req = 0;
        if (v && !(we || rs)) begin
            m_data = alu; m_rf_we = 1'b1; m_err = 1'b0;
        end else if (v && dly < TO) begin
            e_stall = dly + 1; e_req = dly + 1;
            m_data = rs ? rd : alu; m_rf_we = ~we; m_err = 1'b0;
        end else if (v) begin
            e_stall = TO; e_req = TO;
            m_data = '0; m_rf_we = 1'b0; m_err = 1'b1;
        end
        if (v) begin
            m_np = np; m_rs = rs;
        end
    endtask

    // Present one instruction at posedge+1 and act as the memory until it leaves the stage.
    task automatic drive_instr(input logic v, input logic we, input logic rs, input logic np,
                               input logic [DW-1:0] alu, input logic [DW-1:0] sd,
                               input logic [DW-1:0] rd, input logic [AW-1:0] addr,
                               input int dly, input logic ack_idle);
        logic st;
        o_stall = 0; o_req = 0; o_bus_bad = 0; o_wb = 1'b0;
        in_valid = v; in_dm_we = we; in_rf_d_sel = rs; in_next_pc = np;
        in_alu_res = alu; in_store_data = sd; in_dm_addr = addr;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (dm_req) begin
                if (dm_we !== we || dm_addr !== addr || dm_wdata !== sd) o_bus_bad++;
                if (o_req == dly) begin
                    dm_ack = 1'b1; dm_rdata = rd;
                end
                o_req++;
            end else begin
                if (dm_we !== 1'b0 || dm_addr !== '0 || dm_wdata !== '0) o_bus_bad++;
                dm_ack = ack_idle; dm_rdata = $urandom;
            end
            #1;
            st = stall;
            if (st) o_stall++;
            @(posedge clk);
            #1;
            dm_ack = 1'b0; dm_rdata = $urandom;
            if (wb_valid) begin
                o_wb = 1'b1;
                break;
            end
            if (!st) break;
        end
    endtask

    task automatic go_idle();
        in_valid = 1'b0; in_dm_we = 1'b0; in_rf_d_sel = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; go_idle(); in_next_pc = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
        in_alu_res = '0; in_store_data = '0; in_dm_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({dm_req, dm_we, dm_addr, dm_wdata, stall} !== '0) begin
            bad++; $display("FAIL reset_bus: req=%b we=%b addr=%h wdata=%h stall=%b, want all 0",
                            dm_req, dm_we, dm_addr, dm_wdata, stall);
        end
        total++;
        if ({wb_valid, wb_rf_we, wb_data, wb_next_pc, wb_rf_d_sel, wb_err} !== '0) begin
            bad++; $display("FAIL reset_wb: valid=%b rf_we=%b data=%h np=%b rs=%b err=%b, want all 0",
                            wb_valid, wb_rf_we, wb_data, wb_next_pc, wb_rf_d_sel, wb_err);
        end
        rst = 1'b0;
        m_data = '0; m_rf_we = 1'b0; m_err = 1'b0; m_np = 1'b0; m_rs = 1'b0;
    endtask

    task automatic test_alu();
        logic e_wb; int e_st, e_rq;
        model_step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'h0, 0, e_wb, e_st, e_rq);
        drive_instr(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'h0, 32'h0, 16'h0, 0, 1'b1);
        go_idle();
        total++;
        if (o_wb !== 1'b1 || wb_data !== 32'h0000_1234 || wb_rf_we !== 1'b1 || wb_next_pc !== 1'b1) begin
            bad++; $display("FAIL alu_wb: wb=%b data=%h rf_we=%b np=%b, want 1 00001234 1 1",
                            o_wb, wb_data, wb_rf_we, wb_next_pc);
        end
        total++;
        if (o_stall != e_st || o_req != e_rq || o_bus_bad != 0) begin
            bad++; $display("FAIL alu_stall: stall=%0d req=%0d busbad=%0d, want %0d %0d 0",
                            o_stall, o_req, o_bus_bad, e_st, e_rq);
        end
    endtask

    task automatic test_load();
        logic e_wb; int e_st, e_rq;
        model_step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 3, e_wb, e_st, e_rq);
        drive_instr(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h1111_2222, 32'hDEAD_BEEF,
                    16'h0040, 3, 1'b0);
        go_idle();
        total++;
        if (o_wb !== 1'b1 || wb_data !== 32'hDEAD_BEEF || wb_rf_we !== 1'b1 || wb_err !== 1'b0
            || wb_rf_d_sel !== 1'b1) begin
            bad++; $display("FAIL load_wb: wb=%b data=%h rf_we=%b err=%b rs=%b, want 1 deadbeef 1 0 1",
                            o_wb, wb_data, wb_rf_we, wb_err, wb_rf_d_sel);
        end
        total++;
        if (o_stall != e_st || o_req != e_rq || o_bus_bad != 0) begin
            bad++; $display("FAIL load_timing: stall=%0d req=%0d busbad=%0d, want %0d %0d 0",
                            o_stall, o_req, o_bus_bad, e_st, e_rq);
        end
    endtask

    task automatic test_store();
        logic e_wb; int e_st, e_rq;
        model_step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 0, e_wb, e_st, e_rq);
        drive_instr(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'hA5A5_A5A5, 32'h0,
                    16'h0010, 0, 1'b0);
        go_idle();
        total++;
        if (o_wb !== 1'b1 || wb_rf_we !== 1'b0 || wb_err !== 1'b0) begin
            bad++; $display("FAIL store_wb: wb=%b rf_we=%b err=%b, want 1 0 0", o_wb, wb_rf_we, wb_err);
        end
        total++;
        if (o_req != e_rq || o_stall != e_st || o_bus_bad != 0) begin
            bad++; $display("FAIL store_bus: req=%0d stall=%0d busbad=%0d, want %0d %0d 0",
                            o_req, o_stall, o_bus_bad, e_rq, e_st);
        end
    endtask

    task automatic test_timeout();
        logic e_wb; int e_st, e_rq;
        model_step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0077, 32'h0, NEVER, e_wb, e_st, e_rq);
        drive_instr(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0077, 32'h0, 32'h0, 16'h0100, NEVER, 1'b0);
        total++;
        if (o_wb !== 1'b1 || wb_err !== 1'b1 || wb_data !== '0 || wb_rf_we !== 1'b0) begin
            bad++; $display("FAIL timeout_wb: wb=%b err=%b data=%h rf_we=%b, want 1 1 0 0",
                            o_wb, wb_err, wb_data, wb_rf_we);
        end
        total++;
        if (o_req != e_rq || o_stall != e_st) begin
            bad++; $display("FAIL timeout_len: req=%0d stall=%0d, want %0d %0d", o_req, o_stall, e_rq, e_st);
        end
        model_step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_5555, 32'h0, 0, e_wb, e_st, e_rq);
        drive_instr(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_5555, 32'h0, 32'h0, 16'h0, 0, 1'b0);
        total++;
        if (o_wb !== 1'b1 || wb_err !== 1'b0 || wb_data !== 32'h0000_5555) begin
            bad++; $display("FAIL timeout_clear: wb=%b err=%b data=%h, want 1 0 00005555", o_wb, wb_err, wb_data);
        end
        // Ack on the very last allowed REQ cycle.
        model_step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'hCAFE_F00D, TO - 1, e_wb, e_st, e_rq);
        drive_instr(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D, 16'h0200, TO - 1, 1'b0);
        go_idle();
        total++;
        if (o_wb !== 1'b1 || wb_err !== 1'b0 || wb_data !== 32'hCAFE_F00D || o_req != e_rq) begin
            bad++; $display("FAIL ack_at_timeout: wb=%b err=%b data=%h req=%0d, want 1 0 cafef00d %0d",
                            o_wb, wb_err, wb_data, o_req, e_rq);
        end
    endtask

    task automatic test_back_to_back();
        logic e_wb; int e_st, e_rq;
        int reqs = 0, wbs = 0;
        model_step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1357_9BDF, 0, e_wb, e_st, e_rq);
        drive_instr(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h1357_9BDF, 16'h0A00, 0, 1'b0);
        reqs += o_req; wbs += int'(o_wb);
        total++;
        if (wb_data !== m_data || o_bus_bad != 0) begin
            bad++; $display("FAIL b2b_load: data=%h busbad=%0d, want %h 0", wb_data, o_bus_bad, m_data);
        end
        model_step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 0, e_wb, e_st, e_rq);
        drive_instr(1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0F0F_0F0F, 32'h0, 16'h0B00, 0, 1'b0);
        reqs += o_req; wbs += int'(o_wb);
        go_idle();
        total++;
        if (reqs != 2 || wbs != 2 || o_bus_bad != 0 || wb_rf_we !== 1'b0 || wb_next_pc !== 1'b1) begin
            bad++; $display("FAIL b2b_count: reqs=%0d wbs=%0d busbad=%0d rf_we=%b np=%b, want 2 2 0 0 1",
                            reqs, wbs, o_bus_bad, wb_rf_we, wb_next_pc);
        end
        @(posedge clk); #1;
        total++;
        if (wb_valid !== 1'b0 || dm_req !== 1'b0) begin
            bad++; $display("FAIL b2b_idle: wb_valid=%b dm_req=%b, want 0 0", wb_valid, dm_req);
        end
    endtask

    task automatic test_reset_mid_req();
        in_valid = 1'b1; in_dm_we = 1'b0; in_rf_d_sel = 1'b1; in_dm_addr = 16'h0300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (dm_req !== 1'b1) begin
            bad++; $display("FAIL rst_req_setup: dm_req=%b, want 1", dm_req);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (dm_req !== 1'b0 || wb_valid !== 1'b0) begin
            bad++; $display("FAIL rst_mid_req: dm_req=%b wb_valid=%b, want 0 0", dm_req, wb_valid);
        end
        go_idle(); rst = 1'b0; dm_ack = 1'b1; dm_rdata = 32'h9999_9999;
        @(posedge clk); #1;
        dm_ack = 1'b0;
        total++;
        if (dm_req !== 1'b0 || wb_valid !== 1'b0 || wb_data !== '0) begin
            bad++; $display("FAIL rst_late_ack: dm_req=%b wb_valid=%b data=%h, want 0 0 0",
                            dm_req, wb_valid, wb_data);
        end
        m_data = '0; m_rf_we = 1'b0; m_err = 1'b0; m_np = 1'b0; m_rs = 1'b0;
    endtask

    task automatic test_random();
        logic v, we, rs, np, e_wb;
        logic [DW-1:0] alu, sd, rd;
        logic [AW-1:0] addr;
        int r, dly, e_st, e_rq;
        for (int i = 0; i < 40; i++) begin
            v = ($urandom_range(0, 4) != 0); we = $urandom; rs = $urandom; np = $urandom;
            alu = $urandom; sd = $urandom; rd = $urandom; addr = AW'($urandom);
            r = $urandom_range(0, 9);
            if (r < 5) dly = r;
            else if (r < 7) dly = TO - 1;
            else if (r < 8) dly = TO;
            else dly = NEVER;
            model_step(v, we, rs, np, alu, rd, dly, e_wb, e_st, e_rq);
            drive_instr(v, we, rs, np, alu, sd, rd, addr, dly, 1'($urandom));
            total++;
            if (o_wb !== e_wb || o_stall != e_st || o_req != e_rq || o_bus_bad != 0) begin
                bad++; $display("FAIL rand_flow[%0d]: wb=%b stall=%0d req=%0d busbad=%0d, want %b %0d %0d 0",
                                i, o_wb, o_stall, o_req, o_bus_bad, e_wb, e_st, e_rq);
            end
            total++;
            if (wb_data !== m_data || wb_rf_we !== m_rf_we || wb_err !== m_err
                || wb_next_pc !== m_np || wb_rf_d_sel !== m_rs) begin
                bad++; $display("FAIL rand_wb[%0d]: data=%h rf_we=%b err=%b np=%b rs=%b, want %h %b %b %b %b",
                                i, wb_data, wb_rf_we, wb_err, wb_next_pc, wb_rf_d_sel,
                                m_data, m_rf_we, m_err, m_np, m_rs);
            end
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_timeout();
        test_back_to_back();
        test_reset_mid_req();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
